// File: rtl/ppm_pkg.sv
// Shared PPM frame-buffer definitions used by both the receive and transmit buffers.
package ppm_pkg;

  localparam int unsigned FRAME_MAX_BYTES = 16;

  // One-hot state encodings kept as plain constants for legacy compatibility.
  localparam logic [3:0] ST_IDLE       = 4'b0001;
  localparam logic [3:0] ST_RECV_FRAME = 4'b0010;
  localparam logic [3:0] ST_PRESENT    = 4'b0100;
  localparam logic [3:0] ST_FLUSH      = 4'b1000;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] ptr_t;

endpackage

// File: rtl/ppm_rx_timeout.sv
// Saturating 16-bit idle timer; expired flags the last permitted idle cycle.
module ppm_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = ({16'd0, count_q} >= (TIMEOUT_CYCLES - 32'd1));

endmodule

// File: rtl/ppm_rx_frame_buffer.sv
// Receive frame buffer: collects N payload bytes, then presents them to the user one per accept.
module ppm_rx_frame_buffer
  import ppm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sof_detected,
  input  logic [3:0] N,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       user_rd,
  output logic [7:0] Dout,
  output logic       Dout_valid,
  output logic [3:0] frame_len,
  output logic       frame_done,
  output logic       frame_err
);

  logic [3:0] state_q, state_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  logic [3:0] frame_len_q, frame_len_d;
  byte_t      dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       frame_done_q, frame_done_d;
  byte_t      buffer_q [FRAME_MAX_BYTES];

  logic in_recv;
  logic wr_en;
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;

  assign in_recv    = (state_q == ST_RECV_FRAME);
  assign wr_en      = in_recv && byte_valid;
  assign tmr_clear  = !in_recv || byte_valid;
  assign tmr_enable = in_recv && !byte_valid;

  ppm_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_len_d  = frame_len_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sof_detected && (N != 4'd0)) begin
          frame_len_d = N;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          state_d     = ST_RECV_FRAME;
        end
      end
      ST_RECV_FRAME: begin
        if (byte_valid) begin
          wr_ptr_d = wr_ptr_q + 4'd1;
          if (wr_ptr_q == frame_len_q - 4'd1) begin
            state_d      = ST_PRESENT;
            rd_ptr_d     = '0;
            dout_valid_d = 1'b1;
            // Single-byte frames: byte 0 is being written this very cycle.
            dout_d       = (wr_ptr_q == 4'd0) ? byte_in : buffer_q[0];
          end
        end else if (tmr_expired) begin
          state_d = ST_FLUSH;
        end
      end
      ST_PRESENT: begin
        if (user_rd && dout_valid_q) begin
          if (rd_ptr_q == frame_len_q - 4'd1) begin
            state_d      = ST_IDLE;
            dout_d       = '0;
            dout_valid_d = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 4'd1;
            dout_d   = buffer_q[rd_ptr_q + 4'd1];
          end
        end
      end
      ST_FLUSH: begin
        wr_ptr_d = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        dout_d       = '0;
        dout_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_len_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_len_q  <= frame_len_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Payload storage is deliberately left unreset; it is only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer_q[wr_ptr_q] <= byte_in;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dout_valid_q;
  assign frame_len  = frame_len_q;
  assign frame_done = frame_done_q;
  assign frame_err  = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_ppm_rx_frame_buffer.sv
// Directed and randomized checks of ppm_rx_frame_buffer against a byte-queue reference model.
module tb_ppm_rx_frame_buffer;

  localparam int unsigned T = 20;

  logic       clk;
  logic       rst_n;
  logic       sof_detected;
  logic [3:0] N;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       user_rd;
  logic [7:0] Dout;
  logic       Dout_valid;
  logic [3:0] frame_len;
  logic       frame_done;
  logic       frame_err;

  int unsigned vectors;
  int unsigned miscompares;
  logic [7:0]  exp_q[$];

  ppm_rx_frame_buffer #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sof_detected(sof_detected),
    .N           (N),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .user_rd     (user_rd),
    .Dout        (Dout),
    .Dout_valid  (Dout_valid),
    .frame_len   (frame_len),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    sof_detected = 1'b0;
    N            = 4'd0;
    byte_valid   = 1'b0;
    byte_in      = 8'h00;
    user_rd      = 1'b0;
  endtask

  task automatic send_sof(input logic [3:0] n);
    quiet();
    sof_detected = 1'b1;
    N            = n;
    cyc();
    quiet();
  endtask

  // gap idle cycles (optionally with ignored junk) then one byte cycle
  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit junk);
    for (int unsigned i = 0; i < gap; i++) begin
      quiet();
      if (junk) begin
        sof_detected = ($urandom_range(0, 3) == 0);
        N            = 4'($urandom);
        user_rd      = 1'($urandom);
      end
      cyc();
      chk("recv_no_err", {31'd0, frame_err}, 32'd0);
      chk("recv_no_valid", {31'd0, Dout_valid}, 32'd0);
    end
    quiet();
    byte_valid = 1'b1;
    byte_in    = b;
    exp_q.push_back(b);
    cyc();
    quiet();
  endtask

  // mode 0: read every cycle, 1: every other cycle, 2: random with junk inputs
  task automatic drain(input int unsigned mode);
    int unsigned budget;
    int unsigned phase;
    bit          rd;
    budget = 200;
    phase  = 0;
    while (exp_q.size() != 0 && budget != 0) begin
      chk("present_valid", {31'd0, Dout_valid}, 32'd1);
      chk("present_dout", {24'd0, Dout}, {24'd0, exp_q[0]});
      chk("present_no_done", {31'd0, frame_done}, 32'd0);
      case (mode)
        0:       rd = 1'b1;
        1:       rd = phase[0];
        default: rd = 1'($urandom);
      endcase
      quiet();
      if (mode == 2) begin
        sof_detected = 1'($urandom);
        N            = 4'($urandom);
        byte_valid   = 1'($urandom);
        byte_in      = 8'($urandom);
      end
      user_rd = rd;
      if (rd) void'(exp_q.pop_front());
      phase++;
      budget--;
      cyc();
    end
    quiet();
    chk("drain_budget", budget, (budget == 0) ? 32'd1 : budget);
    chk("done_pulse", {31'd0, frame_done}, 32'd1);
    chk("done_valid_clr", {31'd0, Dout_valid}, 32'd0);
    chk("done_dout_clr", {24'd0, Dout}, 32'd0);
    user_rd = 1'b1;
    cyc();
    chk("done_single", {31'd0, frame_done}, 32'd0);
    chk("idle_rd_noeffect", {31'd0, Dout_valid}, 32'd0);
    quiet();
  endtask

  initial begin
    int unsigned n;
    vectors     = 0;
    miscompares = 0;
    quiet();
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_dout", {24'd0, Dout}, 32'd0);
    chk("rst_valid", {31'd0, Dout_valid}, 32'd0);
    chk("rst_len", {28'd0, frame_len}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // three bytes, continuous read
    send_sof(4'd3);
    chk("len3", {28'd0, frame_len}, 32'd3);
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h3C, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    drain(0);
    chk("len3_hold", {28'd0, frame_len}, 32'd3);

    // two bytes, toggled read
    send_sof(4'd2);
    send_byte(8'h11, 1, 1'b0);
    send_byte(8'h22, 2, 1'b0);
    drain(1);
    repeat (3) begin
      cyc();
      chk("no_extra_done", {31'd0, frame_done}, 32'd0);
    end

    // timeout after two of four bytes
    send_sof(4'd4);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    exp_q.delete();
    for (int unsigned i = 1; i <= T; i++) begin
      cyc();
      chk("to_valid", {31'd0, Dout_valid}, 32'd0);
      chk("to_err", {31'd0, frame_err}, (i == T) ? 32'd1 : 32'd0);
    end
    cyc();
    chk("to_err_pulse", {31'd0, frame_err}, 32'd0);
    chk("to_valid_after", {31'd0, Dout_valid}, 32'd0);

    // N=0 ignored, then N=1
    send_sof(4'd0);
    chk("n0_len_hold", {28'd0, frame_len}, 32'd4);
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    cyc();
    quiet();
    chk("n0_idle", {31'd0, Dout_valid}, 32'd0);
    send_sof(4'd1);
    chk("len1", {28'd0, frame_len}, 32'd1);
    send_byte(8'h5A, 0, 1'b0);
    drain(0);

    // second SOF mid-frame ignored
    send_sof(4'd3);
    send_byte(8'hC1, 0, 1'b0);
    sof_detected = 1'b1;
    N            = 4'd7;
    cyc();
    quiet();
    chk("mid_sof_len", {28'd0, frame_len}, 32'd3);
    send_byte(8'hC2, 0, 1'b0);
    send_byte(8'hC3, 1, 1'b1);
    drain(0);

    // byte arriving on the final timeout cycle wins
    send_sof(4'd2);
    send_byte(8'h77, T - 1, 1'b0);
    send_byte(8'h88, T - 1, 1'b0);
    chk("edge_no_err", {31'd0, frame_err}, 32'd0);
    drain(0);

    // reset mid-PRESENT, then a fresh frame
    send_sof(4'd5);
    for (int unsigned i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 0, 1'b0);
    user_rd = 1'b1;
    cyc();
    cyc();
    chk("pre_rst_dout", {24'd0, Dout}, 32'h32);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, Dout_valid}, 32'd0);
    cyc();
    chk("rst_mid_dout", {24'd0, Dout}, 32'd0);
    chk("rst_mid_valid", {31'd0, Dout_valid}, 32'd0);
    chk("rst_mid_len", {28'd0, frame_len}, 32'd0);
    chk("rst_mid_done", {31'd0, frame_done}, 32'd0);
    chk("rst_mid_err", {31'd0, frame_err}, 32'd0);
    quiet();
    rst_n = 1'b1;
    exp_q.delete();
    cyc();
    send_sof(4'd1);
    send_byte(8'h9D, 0, 1'b0);
    drain(0);

    // randomized frames, including the 15-byte maximum
    for (int unsigned f = 0; f < 12; f++) begin
      n = (f == 0) ? 15 : $urandom_range(1, 15);
      send_sof(4'(n));
      chk("rand_len", {28'd0, frame_len}, n);
      for (int unsigned i = 0; i < n; i++)
        send_byte(8'($urandom), $urandom_range(0, T - 1), 1'b1);
      drain(2);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
